// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues req/ack reads to instruction memory and holds
// the returned word for decode behind a valid/ready handshake, with branch redirect.
module instruction_fetch #(
    parameter int                     INSTR_WIDTH = 8,
    parameter int                     PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    output logic                      imem_req,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic                      imem_ack,
    input  logic [INSTR_WIDTH-1:0]    imem_rdata,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [INSTR_WIDTH-1:0]    instr,
    output logic [1:0]                opcode,
    output logic [PC_WIDTH-1:0]       instr_pc,
    input  logic                      branch_taken,
    input  logic [PC_WIDTH-1:0]       branch_target
);

    typedef enum logic {
        S_REQ,
        S_HOLD
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] fetch_addr;
    logic                kill;

    // The address register only moves when no request is outstanding.
    assign imem_addr = fetch_addr;
    assign opcode    = instr[INSTR_WIDTH-1 -: 2];

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; the async reset clears everything without a clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            fetch_addr  <= RESET_PC;
            kill        <= 1'b0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (!imem_req) begin
                        // First cycle out of reset: no request in flight yet.
                        imem_req <= 1'b1;
                        if (branch_taken) begin
                            pc         <= branch_target;
                            fetch_addr <= branch_target;
                        end
                    end else if (branch_taken) begin
                        pc <= branch_target;
                        if (imem_ack) begin
                            fetch_addr <= branch_target;
                            kill       <= 1'b0;
                        end else begin
                            // Request must complete at the old address; drop its data later.
                            kill <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        if (kill) begin
                            kill       <= 1'b0;
                            fetch_addr <= pc;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= fetch_addr;
                            pc          <= fetch_addr + PC_WIDTH'(1);
                            instr_valid <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        pc          <= branch_target;
                        fetch_addr  <= branch_target;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end else if (instr_ready) begin
                        fetch_addr  <= pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a configurable-latency memory model.
module tb_instruction_fetch;

    logic       clock;
    logic       reset_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [1:0] opcode;
    logic [7:0] instr_pc;
    logic       branch_taken;
    logic [7:0] branch_target;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    int         lat;
    int         wait_cnt;

    instruction_fetch #(
        .INSTR_WIDTH(8),
        .PC_WIDTH   (8),
        .RESET_PC   (8'h00)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .opcode       (opcode),
        .instr_pc     (instr_pc),
        .branch_taken (branch_taken),
        .branch_target(branch_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory answers once a request has been waiting lat cycles.
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = mem[imem_addr];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)      wait_cnt <= 0;
        else if (imem_ack) wait_cnt <= 0;
        else if (imem_req) wait_cnt <= wait_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        instr_ready   = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        lat           = 0;
        #3;
        checks++; if (imem_req !== 1'b0)    begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 8'h00)      begin errors++; $display("FAIL reset_instr got %h want 00", instr); end
        checks++; if (opcode !== 2'b00)     begin errors++; $display("FAIL reset_opcode got %b want 00", opcode); end
        checks++; if (instr_pc !== 8'h00)   begin errors++; $display("FAIL reset_instr_pc got %h want 00", instr_pc); end
        checks++; if (imem_addr !== 8'h00)  begin errors++; $display("FAIL reset_addr got %h want 00", imem_addr); end
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL req_before_first_edge got %b want 0", imem_req); end
        step();
        checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL req_first_cycle got %b want 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL addr_first_cycle got %h want 00", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [7:0] words [4];
        words[0] = 8'h00; words[1] = 8'h41; words[2] = 8'h82; words[3] = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1)      begin errors++; $display("FAIL seq%0d_req got %b want 1", i, imem_req); end
            checks++; if (imem_addr !== 8'(i))    begin errors++; $display("FAIL seq%0d_addr got %h want %h", i, imem_addr, 8'(i)); end
            checks++; if (instr_valid !== 1'b0)   begin errors++; $display("FAIL seq%0d_valid_low got %b want 0", i, instr_valid); end
            step();
            checks++; if (instr_valid !== 1'b1)   begin errors++; $display("FAIL seq%0d_valid got %b want 1", i, instr_valid); end
            checks++; if (instr !== words[i])     begin errors++; $display("FAIL seq%0d_instr got %h want %h", i, instr, words[i]); end
            checks++; if (opcode !== 2'(i))       begin errors++; $display("FAIL seq%0d_opcode got %b want %b", i, opcode, 2'(i)); end
            checks++; if (instr_pc !== 8'(i))     begin errors++; $display("FAIL seq%0d_instr_pc got %h want %h", i, instr_pc, 8'(i)); end
            checks++; if (imem_req !== 1'b0)      begin errors++; $display("FAIL seq%0d_req_low got %b want 0", i, imem_req); end
            step();
        end
        checks++; if (imem_addr !== 8'h04) begin errors++; $display("FAIL seq_next_addr got %h want 04", imem_addr); end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", instr_valid); end
        checks++; if (instr !== 8'h6B)      begin errors++; $display("FAIL stall_instr got %h want 6B", instr); end
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid got %b want 1", c, instr_valid); end
            checks++; if (instr !== 8'h6B)      begin errors++; $display("FAIL stall%0d_instr got %h want 6B", c, instr); end
            checks++; if (opcode !== 2'b01)     begin errors++; $display("FAIL stall%0d_opcode got %b want 01", c, opcode); end
            checks++; if (instr_pc !== 8'h04)   begin errors++; $display("FAIL stall%0d_instr_pc got %h want 04", c, instr_pc); end
            checks++; if (imem_req !== 1'b0)    begin errors++; $display("FAIL stall%0d_req got %b want 0", c, imem_req); end
        end
        instr_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1)    begin errors++; $display("FAIL stall_release_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 8'h05)  begin errors++; $display("FAIL stall_release_addr got %h want 05", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b want 0", instr_valid); end
    endtask

    task automatic test_branch_wait();
        int n;
        lat           = 3;
        branch_taken  = 1'b1;
        branch_target = 8'h20;
        step();
        branch_taken = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (imem_req !== 1'b1)    begin errors++; $display("FAIL bw%0d_req got %b want 1", c, imem_req); end
            checks++; if (imem_addr !== 8'h05)  begin errors++; $display("FAIL bw%0d_addr_held got %h want 05", c, imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bw%0d_valid got %b want 0", c, instr_valid); end
            step();
        end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bw_killed_valid got %b want 0", instr_valid); end
        checks++; if (imem_req !== 1'b1)    begin errors++; $display("FAIL bw_retarget_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 8'h20)  begin errors++; $display("FAIL bw_retarget_addr got %h want 20", imem_addr); end
        n = 0;
        while (!instr_valid && n < 10) begin
            step();
            n++;
        end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bw_timeout valid got %b want 1 within 10 cycles", instr_valid); end
        checks++; if (instr_pc !== 8'h20)   begin errors++; $display("FAIL bw_instr_pc got %h want 20", instr_pc); end
        checks++; if (instr !== 8'h5A)      begin errors++; $display("FAIL bw_instr got %h want 5A", instr); end
        lat = 0;
    endtask

    task automatic test_branch_ack();
        step();
        checks++; if (imem_addr !== 8'h21) begin errors++; $display("FAIL ba_addr got %h want 21", imem_addr); end
        branch_taken  = 1'b1;
        branch_target = 8'h30;
        step();
        branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ba_valid got %b want 0", instr_valid); end
        checks++; if (imem_req !== 1'b1)    begin errors++; $display("FAIL ba_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 8'h30)  begin errors++; $display("FAIL ba_addr_target got %h want 30", imem_addr); end
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ba_new_valid got %b want 1", instr_valid); end
        checks++; if (instr_pc !== 8'h30)   begin errors++; $display("FAIL ba_instr_pc got %h want 30", instr_pc); end
        checks++; if (instr !== 8'h7E)      begin errors++; $display("FAIL ba_instr got %h want 7E", instr); end
    endtask

    task automatic test_branch_hold();
        branch_taken  = 1'b1;
        branch_target = 8'h10;
        step();
        branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bh_valid got %b want 0", instr_valid); end
        checks++; if (imem_req !== 1'b1)    begin errors++; $display("FAIL bh_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 8'h10)  begin errors++; $display("FAIL bh_addr got %h want 10", imem_addr); end
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bh_new_valid got %b want 1", instr_valid); end
        checks++; if (instr_pc !== 8'h10)   begin errors++; $display("FAIL bh_instr_pc got %h want 10", instr_pc); end
        checks++; if (instr !== 8'h96)      begin errors++; $display("FAIL bh_instr got %h want 96", instr); end
    endtask

    task automatic test_wrap();
        branch_taken  = 1'b1;
        branch_target = 8'hFF;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_addr got %h want FF", imem_addr); end
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", instr_valid); end
        checks++; if (instr_pc !== 8'hFF)   begin errors++; $display("FAIL wrap_instr_pc got %h want FF", instr_pc); end
        checks++; if (instr !== 8'hE7)      begin errors++; $display("FAIL wrap_instr got %h want E7", instr); end
        checks++; if (opcode !== 2'b11)     begin errors++; $display("FAIL wrap_opcode got %b want 11", opcode); end
        step();
        checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL wrap_next_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_next_addr got %h want 00", imem_addr); end
    endtask

    task automatic test_reset_mid();
        step();
        step();
        instr_ready = 1'b0;
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b want 1", instr_valid); end
        checks++; if (instr !== 8'h41)      begin errors++; $display("FAIL rm_pre_instr got %h want 41", instr); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", instr_valid); end
        checks++; if (instr !== 8'h00)      begin errors++; $display("FAIL rm_instr got %h want 00", instr); end
        checks++; if (opcode !== 2'b00)     begin errors++; $display("FAIL rm_opcode got %b want 00", opcode); end
        checks++; if (instr_pc !== 8'h00)   begin errors++; $display("FAIL rm_instr_pc got %h want 00", instr_pc); end
        checks++; if (imem_req !== 1'b0)    begin errors++; $display("FAIL rm_req got %b want 0", imem_req); end
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n     = 1'b1;
        instr_ready = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL rm_first_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rm_first_addr got %h want 00", imem_addr); end
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rm_first_valid got %b want 1", instr_valid); end
        checks++; if (instr_pc !== 8'h00)   begin errors++; $display("FAIL rm_first_instr_pc got %h want 00", instr_pc); end
        checks++; if (instr !== 8'h00)      begin errors++; $display("FAIL rm_first_instr got %h want 00", instr); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h00] = 8'h00;
        mem[8'h01] = 8'h41;
        mem[8'h02] = 8'h82;
        mem[8'h03] = 8'hC3;
        mem[8'h04] = 8'h6B;
        mem[8'h05] = 8'hD4;
        mem[8'h10] = 8'h96;
        mem[8'h20] = 8'h5A;
        mem[8'h30] = 8'h7E;
        mem[8'hFF] = 8'hE7;

        test_reset();
        test_sequential();
        test_stall();
        test_branch_wait();
        test_branch_ack();
        test_branch_hold();
        test_wrap();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
